// File: rtl/gemm_tile_sequencer.sv
// Tiled-GEMM issue sequencer: walks M/K/N as RowPar x ColPar tiles, drives SRAM A/B reads,
// aligns PE valid/clear to read data and emits one C write per tile.
module gemm_tile_sequencer #(
  parameter int unsigned RowPar        = 4,
  parameter int unsigned ColPar        = 16,
  parameter int unsigned AddrWidth     = 12,
  parameter int unsigned SizeAddrWidth = 32,
  parameter int unsigned ReadLatency   = 1,
  parameter int unsigned MacLatency    = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [SizeAddrWidth-1:0] M_size_i,
  input  logic [SizeAddrWidth-1:0] K_size_i,
  input  logic [SizeAddrWidth-1:0] N_size_i,
  input  logic [AddrWidth-1:0]     c_base_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [AddrWidth-1:0]     sram_a_addr_o,
  output logic [AddrWidth-1:0]     sram_b_addr_o,
  output logic                     mac_valid_o,
  output logic                     acc_clear_o,
  output logic [AddrWidth-1:0]     sram_c_addr_o,
  output logic                     sram_c_we_o
);

  localparam int unsigned Depth = ReadLatency + MacLatency;
  localparam int unsigned SW    = SizeAddrWidth + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                       state_q, state_d;
  logic [SizeAddrWidth-1:0]     m_size_q, k_size_q, n_size_q, k_q;
  logic [SW-1:0]                m_off_q, n_off_q;
  logic [AddrWidth-1:0]         a_addr_q, a_row_q, b_addr_q, c_addr_q;
  logic [Depth-1:0]             pv_q, pf_q, pl_q;
  logic [Depth-1:0][AddrWidth-1:0] pc_q;

  logic issue, last_k, last_cb, last_rb, last_issue, size_zero, start_run;

  assign issue      = (state_q == StRun);
  assign last_k     = (k_q == k_size_q - SizeAddrWidth'(1));
  assign last_cb    = (n_off_q + SW'(ColPar) >= {1'b0, n_size_q});
  assign last_rb    = (m_off_q + SW'(RowPar) >= {1'b0, m_size_q});
  assign last_issue = issue && last_k && last_cb && last_rb;
  assign size_zero  = (M_size_i == '0) || (K_size_i == '0) || (N_size_i == '0);
  assign start_run  = (state_q == StIdle) && start_i && !size_zero;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = size_zero ? StDone : StRun;
      StRun:   if (last_issue) state_d = StDrain;
      // Leave once only the final stage still holds data; it retires on this edge.
      StDrain: if (pv_q[Depth-2:0] == '0) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      m_size_q <= '0;
      k_size_q <= '0;
      n_size_q <= '0;
      k_q      <= '0;
      m_off_q  <= '0;
      n_off_q  <= '0;
      a_addr_q <= '0;
      a_row_q  <= '0;
      b_addr_q <= '0;
      c_addr_q <= '0;
      pv_q     <= '0;
      pf_q     <= '0;
      pl_q     <= '0;
      pc_q     <= '0;
    end else begin
      state_q <= state_d;
      pv_q    <= {pv_q[Depth-2:0], issue};
      pf_q    <= {pf_q[Depth-2:0], issue && (k_q == '0)};
      pl_q    <= {pl_q[Depth-2:0], issue && last_k};
      pc_q    <= {pc_q[Depth-2:0], c_addr_q};
      if (start_run) begin
        m_size_q <= M_size_i;
        k_size_q <= K_size_i;
        n_size_q <= N_size_i;
        k_q      <= '0;
        m_off_q  <= '0;
        n_off_q  <= '0;
        a_addr_q <= '0;
        a_row_q  <= '0;
        b_addr_q <= '0;
        c_addr_q <= c_base_i;
      end else if (issue && !last_issue) begin
        if (!last_k) begin
          k_q      <= k_q + SizeAddrWidth'(1);
          a_addr_q <= a_addr_q + AddrWidth'(1);
          b_addr_q <= b_addr_q + AddrWidth'(1);
        end else begin
          k_q      <= '0;
          c_addr_q <= c_addr_q + AddrWidth'(1);
          if (!last_cb) begin
            // Same A row block again; B runs on contiguously into the next column block.
            n_off_q  <= n_off_q + SW'(ColPar);
            a_addr_q <= a_row_q;
            b_addr_q <= b_addr_q + AddrWidth'(1);
          end else begin
            n_off_q  <= '0;
            m_off_q  <= m_off_q + SW'(RowPar);
            a_addr_q <= a_addr_q + AddrWidth'(1);
            a_row_q  <= a_addr_q + AddrWidth'(1);
            b_addr_q <= '0;
          end
        end
      end
    end
  end

  assign busy_o        = (state_q == StRun) || (state_q == StDrain);
  assign done_o        = (state_q == StDone);
  assign sram_a_addr_o = a_addr_q;
  assign sram_b_addr_o = b_addr_q;
  assign mac_valid_o   = pv_q[ReadLatency-1];
  assign acc_clear_o   = pv_q[ReadLatency-1] && pf_q[ReadLatency-1];
  assign sram_c_we_o   = pv_q[Depth-1] && pl_q[Depth-1];
  assign sram_c_addr_o = sram_c_we_o ? pc_q[Depth-1] : '0;

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Scoreboard bench for gemm_tile_sequencer: two instances (RL=ML=1 and RL=3/ML=2),
// expected read/write/done events queued at launch and popped as the DUT produces them.
module tb_gemm_tile_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start0, start1;
  logic [31:0] m_sz, k_sz, n_sz;
  logic [11:0] c_base;

  logic        busy0, done0, mv0, clr0, we0, busy1, done1, mv1, clr1, we1;
  logic [11:0] a0, b0, c0, a1, b1, c1;

  always #5 clk = ~clk;

  gemm_tile_sequencer dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start0),
    .M_size_i(m_sz), .K_size_i(k_sz), .N_size_i(n_sz), .c_base_i(c_base),
    .busy_o(busy0), .done_o(done0), .sram_a_addr_o(a0), .sram_b_addr_o(b0),
    .mac_valid_o(mv0), .acc_clear_o(clr0), .sram_c_addr_o(c0), .sram_c_we_o(we0)
  );

  gemm_tile_sequencer #(.ReadLatency(3), .MacLatency(2)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start1),
    .M_size_i(m_sz), .K_size_i(k_sz), .N_size_i(n_sz), .c_base_i(c_base),
    .busy_o(busy1), .done_o(done1), .sram_a_addr_o(a1), .sram_b_addr_o(b1),
    .mac_valid_o(mv1), .acc_clear_o(clr1), .sram_c_addr_o(c1), .sram_c_we_o(we1)
  );

  int sel = 0;
  logic        busy, done, mv, clr, we;
  logic [11:0] a, b, c;
  assign busy = (sel != 0) ? busy1 : busy0;
  assign done = (sel != 0) ? done1 : done0;
  assign mv   = (sel != 0) ? mv1   : mv0;
  assign clr  = (sel != 0) ? clr1  : clr0;
  assign we   = (sel != 0) ? we1   : we0;
  assign a    = (sel != 0) ? a1    : a0;
  assign b    = (sel != 0) ? b1    : b0;
  assign c    = (sel != 0) ? c1    : c0;

  typedef struct packed {
    logic [15:0] cyc;
    logic [11:0] a;
    logic [11:0] b;
    logic        clr;
    logic        vld;
  } mac_t;

  typedef struct packed {
    logic [15:0] cyc;
    logic [11:0] addr;
  } wr_t;

  mac_t        q_mac[$];
  wr_t         q_wr[$];
  logic [15:0] exp_done;
  bit          en = 1'b0;
  bit          done_seen;
  int          cyc = 0;
  int          start_edge = 0;
  int          cur_rl = 1;
  int          tests = 0;
  int          fails = 0;
  logic [11:0] ah[8], bh[8];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sample mid-cycle, recover issue-time addresses from a short history.
  always @(negedge clk) begin
    logic [15:0] rel;
    mac_t        e, o;
    wr_t         w, ow;
    for (int i = 7; i > 0; i--) begin
      ah[i] = ah[i-1];
      bh[i] = bh[i-1];
    end
    ah[0] = a;
    bh[0] = b;
    if (en) begin
      rel = 16'(cyc - start_edge + 1);
      if (mv || clr) begin
        chk("mac_expected", 64'(q_mac.size() != 0), 64'd1);
        if (q_mac.size() != 0) begin
          e = q_mac.pop_front();
          o = '{cyc: rel, a: ah[cur_rl], b: bh[cur_rl], clr: clr, vld: mv};
          chk("mac_event", 64'(o), 64'(e));
        end
      end
      if (we) begin
        chk("wr_expected", 64'(q_wr.size() != 0), 64'd1);
        if (q_wr.size() != 0) begin
          w  = q_wr.pop_front();
          ow = '{cyc: rel, addr: c};
          chk("c_write", 64'(ow), 64'(w));
        end
      end
      if (done) begin
        chk("done_cycle_busy", {rel, busy}, {exp_done, 1'b0});
        done_seen = 1'b1;
      end
    end
  end

  task automatic launch(input int s, input int unsigned m, input int unsigned k,
                        input int unsigned n, input int unsigned base,
                        input int rl, input int ml);
    int unsigned mt, nt, t;
    q_mac.delete();
    q_wr.delete();
    done_seen = 1'b0;
    mt = (m + 3) / 4;
    nt = (n + 15) / 16;
    t  = 0;
    if (m == 0 || k == 0 || n == 0) begin
      exp_done = 16'd1;
    end else begin
      for (int unsigned rb = 0; rb < mt; rb++)
        for (int unsigned cb = 0; cb < nt; cb++)
          for (int unsigned kk = 0; kk < k; kk++) begin
            t++;
            q_mac.push_back('{cyc: 16'(t + rl), a: 12'(rb * k + kk), b: 12'(cb * k + kk),
                              clr: (kk == 0), vld: 1'b1});
            if (kk == k - 1) q_wr.push_back('{cyc: 16'(t + rl + ml), addr: 12'(base + rb * nt + cb)});
          end
      exp_done = 16'(t + rl + ml + 1);
    end
    @(negedge clk);
    sel    = s;
    cur_rl = rl;
    m_sz   = m;
    k_sz   = k;
    n_sz   = n;
    c_base = 12'(base);
    if (s == 0) start0 = 1'b1;
    else        start1 = 1'b1;
    @(posedge clk);
    #1;
    start_edge = cyc;
    en     = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic finish_run(input int budget);
    int n = 0;
    while (!done_seen && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("done_seen", 64'(done_seen), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("mac_left", 64'(q_mac.size()), 64'd0);
    chk("wr_left", 64'(q_wr.size()), 64'd0);
    en = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    m_sz   = '0;
    k_sz   = '0;
    n_sz   = '0;
    c_base = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs0", {busy0, done0, mv0, clr0, we0, a0, b0, c0}, '0);
    chk("reset_outs1", {busy1, done1, mv1, clr1, we1, a1, b1, c1}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full 32^3 problem: 8x2 tiles of K=32.
    launch(0, 32, 32, 32, 0, 1, 1);
    finish_run(600);
    chk("hold_a", 64'(a0), 64'd255);
    chk("hold_b", 64'(b0), 64'd63);
    chk("idle_flags", {busy0, done0, mv0, clr0, we0}, '0);

    // Single tile, long K.
    launch(0, 4, 64, 16, 0, 1, 1);
    finish_run(100);

    // Ragged edges, runtime C base; start pulse mid-run must be ignored.
    launch(0, 5, 3, 17, 100, 1, 1);
    repeat (3) @(negedge clk);
    m_sz   = 8;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    finish_run(40);

    // Zero inner dimension: straight to done.
    launch(0, 8, 0, 8, 0, 1, 1);
    finish_run(10);

    // Longer pipeline instance.
    launch(1, 4, 4, 4, 0, 3, 2);
    finish_run(40);

    // Reset mid-run aborts without done.
    launch(0, 32, 32, 32, 0, 1, 1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    en = 1'b0;
    chk("abort_outs", {busy0, done0, mv0, clr0, we0, a0, b0, c0}, '0);
    q_mac.delete();
    q_wr.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_done_after_abort", {busy0, done0}, 2'b00);
    end

    // Clean run after abort.
    launch(0, 4, 64, 16, 7, 1, 1);
    finish_run(100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
